// File: rtl/pong_ai_paddle_driver.sv
// Computer opponent for Pong: drives the second paddle's Up/Dn button levels by
// chasing the ball row after a fixed reaction delay.
module pong_ai_paddle_driver #(
  parameter int unsigned c_PADDLE_HEIGHT = 6,
  parameter int unsigned c_GAME_HEIGHT   = 30,
  parameter int unsigned c_REACTION_CLKS = 2500000,
  parameter int unsigned c_DEADBAND      = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Enable,
  input  logic [5:0] i_Ball_Y,
  input  logic [5:0] i_Paddle_Y,
  output logic       o_Paddle_Up,
  output logic       o_Paddle_Dn,
  output logic       o_Busy
);

  localparam int unsigned TIMER_W = 32;

  localparam logic [5:0]         c_BOTTOM_Y   = 6'(c_GAME_HEIGHT - c_PADDLE_HEIGHT - 1);
  localparam logic [6:0]         c_HALF       = 7'(c_PADDLE_HEIGHT / 2);
  localparam logic signed [7:0]  c_DB         = 8'(c_DEADBAND);
  localparam logic [TIMER_W-1:0] c_TIMER_LOAD = TIMER_W'(c_REACTION_CLKS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_MOVE_UP = 2'd2,
    S_MOVE_DN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic [6:0]        centre;
  logic signed [7:0] err;
  logic              far_up, far_dn, at_top, at_bot;

  // Signed distance from paddle centre to ball row, plus wall flags
  always_comb begin
    centre = {1'b0, i_Paddle_Y} + c_HALF;
    err    = $signed({2'b00, i_Ball_Y}) - $signed({1'b0, centre});
    far_up = err < -c_DB;
    far_dn = err > c_DB;
    at_top = (i_Paddle_Y == 6'd0);
    at_bot = (i_Paddle_Y == c_BOTTOM_Y);
  end

  // Next-state and reaction timer; disable forces idle with highest priority
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    if (!i_Enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (far_up || far_dn) begin
            state_d = S_WAIT;
            timer_d = c_TIMER_LOAD;
          end
        end
        S_WAIT: begin
          if (timer_q != '0) begin
            timer_d = timer_q - TIMER_W'(1);
          end else if (far_up && !at_top) begin
            state_d = S_MOVE_UP;
          end else if (far_dn && !at_bot) begin
            state_d = S_MOVE_DN;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MOVE_UP: begin
          if (err >= 8'sd0 || at_top) state_d = S_IDLE;
        end
        S_MOVE_DN: begin
          if (err <= 8'sd0 || at_bot) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, timer and outputs decoded from next-state so they switch on the same edge
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      o_Paddle_Up <= 1'b0;
      o_Paddle_Dn <= 1'b0;
      o_Busy      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      o_Paddle_Up <= (state_d == S_MOVE_UP);
      o_Paddle_Dn <= (state_d == S_MOVE_DN);
      o_Busy      <= (state_d != S_IDLE);
    end
  end

endmodule
